// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache.
// One CPU word request at a time; 128-bit line fills and evictions.
module dcache_direct_mapped #(
  parameter int NUM_SETS   = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req_valid,
  input  logic         cpu_req_we,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic         cpu_ready,
  output logic         cpu_resp_valid,
  output logic [31:0]  cpu_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int TAG_W = 28 - INDEX_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;
  localparam logic [1:0] S_ALLOC = 2'd3;

  logic [1:0]  state;
  logic        req_we;
  logic [31:2] req_addr;
  logic [31:0] req_wdata;
  logic        first_check;

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];

  logic [INDEX_BITS-1:0] idx;
  logic [1:0]            off;
  logic [TAG_W-1:0]      req_tag;
  logic                  hit;
  logic                  accept;
  logic                  fill;
  logic                  store_hit;
  logic                  unused_addr_bits;

  assign idx     = req_addr[INDEX_BITS+3:4];
  assign off     = req_addr[3:2];
  assign req_tag = req_addr[31:INDEX_BITS+4];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
  assign accept  = cpu_req_valid && cpu_ready;
  assign fill    = (state == S_ALLOC) && mem_req && mem_ready;
  assign store_hit = (state == S_CHECK) && hit && req_we;
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Line storage carries no reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= req_tag;
    end else if (store_hit) begin
      data_q[idx][{off, 5'b0} +: 32] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      first_check    <= 1'b0;
      valid_q        <= '0;
      dirty_q        <= '0;
      cpu_ready      <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_we      <= cpu_req_we;
            req_addr    <= cpu_addr[31:2];
            req_wdata   <= cpu_wdata;
            first_check <= 1'b1;
            cpu_ready   <= 1'b0;
            state       <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            if (req_we) begin
              dirty_q[idx] <= 1'b1;
            end else begin
              cpu_rdata <= data_q[idx][{off, 5'b0} +: 32];
            end
            if (first_check) begin
              hit_count <= hit_count + 32'd1;
            end
            cpu_resp_valid <= 1'b1;
            cpu_ready      <= 1'b1;
            state          <= S_IDLE;
          end else begin
            if (first_check) begin
              miss_count <= miss_count + 32'd1;
            end
            first_check <= 1'b0;
            mem_req     <= 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {tag_q[idx], idx, 4'b0};
              mem_wdata <= data_q[idx];
              state     <= S_WB;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, idx, 4'b0};
              state    <= S_ALLOC;
            end
          end
        end
        S_WB: begin
          if (mem_req && mem_ready) begin
            dirty_q[idx] <= 1'b0;
            mem_req      <= 1'b0;
            state        <= S_ALLOC;
          end
        end
        S_ALLOC: begin
          // Arriving from a writeback, mem_req is low for one cycle first.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, idx, 4'b0};
          end else if (mem_ready) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            mem_req      <= 1'b0;
            state        <= S_CHECK;
          end
        end
        default: begin
          state     <= S_IDLE;
          cpu_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Bench for dcache_direct_mapped: directed scenarios, then random traffic
// checked by a scoreboard against a flat-memory reference.
module tb_dcache_direct_mapped;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid;
  logic         cpu_req_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  dcache_direct_mapped #(.NUM_SETS(16), .INDEX_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_tx_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int last_resp_cyc = 0;
  int lat_fixed = -1;
  bit mem_stall = 1'b0;

  exp_t    sb[$];
  mem_tx_t mem_log[$];

  logic [127:0] back [logic [27:0]];
  logic [31:0]  ref_mem [logic [29:0]];
  bit           pv [16];
  logic [23:0]  pt [16];
  int           exp_hit = 0;
  int           exp_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Untouched backing memory: line L word k holds ((L-1)<<8) | (k+1).
  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [31:0] t;
    t = {4'b0, a[31:4]} - 32'd1;
    return (t << 8) | ({30'b0, a[3:2]} + 32'd1);
  endfunction

  function automatic logic [127:0] back_line(input logic [27:0] la);
    logic [127:0] l;
    if (back.exists(la)) return back[la];
    for (int k = 0; k < 4; k++)
      l[32*k +: 32] = init_word({la, k[1:0], 2'b00});
    return l;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word({w, 2'b00});
  endfunction

  // Backing memory: responds after a fixed or random delay.
  initial begin
    int lat;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !mem_stall && !reset) begin
        if (mem_addr[3:0] != 4'b0) chk("mem_addr_align", mem_addr, {mem_addr[31:4], 4'b0});
        lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
        repeat (lat) @(negedge clk);
        if (mem_we) back[mem_addr[31:4]] = mem_wdata;
        else mem_rdata = back_line(mem_addr[31:4]);
        mem_log.push_back('{mem_we, mem_addr, mem_wdata});
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!reset && cpu_resp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_load) chk("load_data", cpu_rdata, e.data);
      end
      resp_cnt++;
      last_resp_cyc = cyc;
    end
  end

  int acc_cyc;

  task automatic do_req(input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input bit wait_resp);
    logic [3:0]  ix;
    logic [23:0] tg;
    int n;
    int target;
    ix = a[7:4];
    tg = a[31:8];
    if (pv[ix] && pt[ix] == tg) exp_hit++;
    else exp_miss++;
    pv[ix] = 1'b1;
    pt[ix] = tg;
    if (we) begin
      ref_mem[a[31:2]] = wd;
      sb.push_back('{1'b0, 32'h0});
    end else begin
      sb.push_back('{1'b1, ref_rd(a[31:2])});
    end
    target = resp_cnt + 1;
    cpu_req_valid = 1'b1;
    cpu_req_we = we;
    cpu_addr = a;
    cpu_wdata = wd;
    n = 0;
    while (!cpu_ready && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (!cpu_ready) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    if (wait_resp) begin
      n = 0;
      while (resp_cnt < target && n < 500) begin
        @(negedge clk); #1; n++;
      end
      if (resp_cnt < target) chk("resp_timeout", resp_cnt, target);
    end
  endtask

  initial begin
    int n;
    logic [127:0] wb_exp;
    reset = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 1);
    chk("rst_resp_valid", cpu_resp_valid, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    #1;

    // Cold load miss, latency 5, line {4,3,2,1}.
    lat_fixed = 5;
    mem_log.delete();
    do_req(1'b0, 32'h10, 0, 1'b1);
    chk("cold_tx_cnt", mem_log.size(), 1);
    if (mem_log.size() >= 1) begin
      chk("cold_tx_we", mem_log[0].we, 0);
      chk("cold_tx_addr", mem_log[0].addr, 32'h10);
    end
    chk("cold_rdata", cpu_rdata, 1);
    chk("cold_miss", miss_count, 1);
    chk("cold_hit", hit_count, 0);

    // Load hit.
    mem_log.delete();
    do_req(1'b0, 32'h14, 0, 1'b1);
    chk("hit_latency", last_resp_cyc - acc_cyc, 2);
    chk("hit_rdata", cpu_rdata, 2);
    chk("hit_tx_cnt", mem_log.size(), 0);
    chk("hit_hits", hit_count, 1);

    // Store hit then load.
    do_req(1'b1, 32'h18, 32'hDEADBEEF, 1'b1);
    do_req(1'b0, 32'h18, 0, 1'b1);
    chk("st_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("st_hits", hit_count, 3);
    chk("st_tx_cnt", mem_log.size(), 0);

    // Dirty conflict.
    wb_exp = 128'h00000004_DEADBEEF_00000002_00000001;
    lat_fixed = 2;
    do_req(1'b0, 32'h110, 0, 1'b1);
    chk("dirty_tx_cnt", mem_log.size(), 2);
    if (mem_log.size() >= 2) begin
      chk("dirty_wb_we", mem_log[0].we, 1);
      chk("dirty_wb_addr", mem_log[0].addr, 32'h10);
      chk("dirty_wb_data", mem_log[0].wdata, wb_exp);
      chk("dirty_fetch_we", mem_log[1].we, 0);
      chk("dirty_fetch_addr", mem_log[1].addr, 32'h110);
    end
    chk("dirty_miss", miss_count, 2);

    // Clean conflict.
    mem_log.delete();
    do_req(1'b0, 32'h210, 0, 1'b1);
    chk("clean_tx_cnt", mem_log.size(), 1);
    if (mem_log.size() >= 1) begin
      chk("clean_fetch_we", mem_log[0].we, 0);
      chk("clean_fetch_addr", mem_log[0].addr, 32'h210);
    end
    chk("clean_miss", miss_count, 3);

    // Reset while a fill is outstanding.
    mem_stall = 1'b1;
    do_req(1'b0, 32'h310, 0, 1'b0);
    n = 0;
    while (!(mem_req && !mem_we) && n < 50) begin
      @(negedge clk); n++;
    end
    chk("alloc_req_seen", mem_req, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_ready", cpu_ready, 1);
    chk("mid_rst_hits", hit_count, 0);
    chk("mid_rst_misses", miss_count, 0);
    sb.delete();
    for (int i = 0; i < 16; i++) pv[i] = 1'b0;
    exp_hit = 0;
    exp_miss = 0;
    ref_mem.delete();
    foreach (back[la])
      for (int k = 0; k < 4; k++)
        ref_mem[{la, k[1:0]}] = back[la][32*k +: 32];
    mem_stall = 1'b0;
    #1;
    mem_log.delete();
    do_req(1'b0, 32'h14, 0, 1'b1);
    chk("post_rst_tx_cnt", mem_log.size(), 1);
    if (mem_log.size() >= 1)
      chk("post_rst_fetch_addr", mem_log[0].addr, 32'h10);
    chk("post_rst_miss", miss_count, 1);

    // Random traffic over 4 tags x 16 sets to force conflicts.
    lat_fixed = -1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {22'b0, 10'($urandom_range(0, 1023))};
      do_req(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
    end
    chk("rand_hits", hit_count, exp_hit);
    chk("rand_misses", miss_count, exp_miss);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
